// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Purpose  : Shares one sprite ROM read port among NUM_REQ renderers on the
//            pixel clock. Round-robin arbitration with optional strict
//            priority for requester 0 and bounded burst locking. Returned ROM
//            data is tagged through a ROM_LAT-deep pipeline and steered back
//            to the requester that issued the read, in issue order.
// Ports    : vga_clk     - pixel clock, all logic on the rising edge
//            reset_n     - synchronous reset, active low
//            req         - per-requester read request (level)
//            lock        - per-requester "keep the grant next cycle"
//            req_addr    - packed request addresses, slice i = requester i
//            gnt         - one-hot grant, combinational in the request cycle
//            rom_address - address to the ROM, 0 when nothing is granted
//            rom_q       - ROM data, valid ROM_LAT cycles after the address
//            rsp_valid   - one-hot response strobe
//            rsp_data    - registered ROM data for the response
//            busy        - any read in flight or response being presented
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 5,
  parameter int ROM_LAT   = 1,
  parameter int MAX_BURST = 20,
  parameter int PRI0      = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  // A cap of one grant means a lock could never outlive its first cycle.
  localparam bit               CAN_LOCK = (MAX_BURST > 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t      state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  logic             rr_found;
  logic [PTR_W-1:0] rr_idx;
  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  logic             pri_win;
  logic             own_win;

  logic [NUM_REQ-1:0] tag [ROM_LAT];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               tag_any;

  // (base + step) mod NUM_REQ, for step < NUM_REQ; NUM_REQ need not be 2^n.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base,
                                                 input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_found && req[wrap_inc(rr_ptr, i)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_inc(rr_ptr, i);
      end
    end
  end

  // Winner selection and lock / pointer next-state.
  always_comb begin
    win_valid     = 1'b0;
    win_idx       = '0;
    pri_win       = 1'b0;
    own_win       = 1'b0;
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    cnt_inc       = burst_cnt + ONE_CNT;

    if (reset_n) begin
      if ((PRI0 != 0) && req[0]) begin
        win_valid = 1'b1;
        pri_win   = 1'b1;
      end else if ((state == LOCKED) && req[owner] && (burst_cnt < MAX_CNT)) begin
        win_valid = 1'b1;
        win_idx   = owner;
        own_win   = 1'b1;
      end else if (rr_found) begin
        win_valid = 1'b1;
        win_idx   = rr_idx;
      end
    end

    if (pri_win) begin
      // The live pixel path breaks any burst and leaves the pointer alone.
      state_nxt     = IDLE;
      burst_cnt_nxt = '0;
    end else if (own_win) begin
      rr_ptr_nxt = wrap_inc(owner, 1);
      if (!lock[owner] || (cnt_inc >= MAX_CNT)) begin
        // Pointer already sits past the owner, so a capped owner loses
        // first choice on the next arbitration.
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end else begin
        burst_cnt_nxt = cnt_inc;
      end
    end else if (win_valid) begin
      // Round-robin grant: a lock taken here is always a fresh one, even if a
      // previous burst is being released in this same cycle.
      rr_ptr_nxt = wrap_inc(rr_idx, 1);
      if (CAN_LOCK && lock[rr_idx]) begin
        state_nxt     = LOCKED;
        owner_nxt     = rr_idx;
        burst_cnt_nxt = ONE_CNT;
      end else begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    end else begin
      state_nxt     = IDLE;
      burst_cnt_nxt = '0;
    end
  end

  always_comb begin
    gnt         = '0;
    rom_address = '0;
    if (win_valid) begin
      gnt[win_idx] = 1'b1;
      rom_address  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Grant tag travels alongside the ROM access; the last stage lines up with
  // rom_q being valid, so data is captured and strobed to the tagged owner.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) tag[i] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag[0] <= gnt;
      for (int i = 1; i < ROM_LAT; i++) tag[i] <= tag[i-1];
      rsp_valid_q <= tag[ROM_LAT-1];
      if (|tag[ROM_LAT-1]) rsp_data_q <= rom_q;
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) tag_any = tag_any | (|tag[i]);
  end

  // Registered state only clears at the reset edge; masking here keeps every
  // output quiet for the whole time reset is held.
  assign rsp_valid = reset_n ? rsp_valid_q : '0;
  assign rsp_data  = reset_n ? rsp_data_q  : '0;
  assign busy      = reset_n & (tag_any | (|rsp_valid_q));

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Purpose  : Self-checking bench for sprite_rom_arbiter. Three instances share
//            the request inputs:
//              0: ROM_LAT=1, PRI0=1, MAX_BURST=20
//              1: ROM_LAT=3, PRI0=0, MAX_BURST=20
//              2: ROM_LAT=2, PRI0=1, MAX_BURST=4
//            Each has its own ROM model; a reference model checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 5;
  localparam int NI = 3;
  localparam logic [N*AW-1:0] ADDRS = {9'h1C3, 9'h0B2, 9'h05A, 9'h011};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N-1:0]      req;
  logic [N-1:0]      lock;
  logic [N*AW-1:0]   req_addr;
  wire  [NI-1:0][N-1:0]  gnt_o;
  wire  [NI-1:0][AW-1:0] addr_o;
  wire  [NI-1:0][N-1:0]  rspv_o;
  wire  [NI-1:0][DW-1:0] rspd_o;
  wire  [NI-1:0]         busy_o;
  logic [NI-1:0][DW-1:0] rom_q_i;
  logic [AW-1:0]         ap [NI][3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1),
                       .MAX_BURST(20), .PRI0(1)) dut_a (
    .vga_clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt_o[0]), .rom_address(addr_o[0]), .rom_q(rom_q_i[0]),
    .rsp_valid(rspv_o[0]), .rsp_data(rspd_o[0]), .busy(busy_o[0]));

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3),
                       .MAX_BURST(20), .PRI0(0)) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt_o[1]), .rom_address(addr_o[1]), .rom_q(rom_q_i[1]),
    .rsp_valid(rspv_o[1]), .rsp_data(rspd_o[1]), .busy(busy_o[1]));

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2),
                       .MAX_BURST(4), .PRI0(1)) dut_c (
    .vga_clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt_o[2]), .rom_address(addr_o[2]), .rom_q(rom_q_i[2]),
    .rsp_valid(rspv_o[2]), .rsp_data(rspd_o[2]), .busy(busy_o[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int pri_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int maxb_of(input int i);
    return (i == 2) ? 4 : 20;
  endfunction

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = (a * 9'd7) + 9'd3;
    t = t ^ (a >> 4);
    return t[DW-1:0];
  endfunction

  // ROM models: address registered, data out lat_of(i) cycles later.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        ap[i][0] <= '0; ap[i][1] <= '0; ap[i][2] <= '0;
      end else begin
        ap[i][0] <= addr_o[i];
        ap[i][1] <= ap[i][0];
        ap[i][2] <= ap[i][1];
      end
    end
  end

  always_comb begin
    rom_q_i = '0;
    for (int i = 0; i < NI; i++) rom_q_i[i] = rom_fn(ap[i][lat_of(i)-1]);
  end

  // ------------------------------------------------------------------
  // Reference model: arbitration rules plus a list of outstanding reads.
  // ------------------------------------------------------------------
  int            m_ptr    [NI];
  int            m_owner  [NI];
  int            m_cnt    [NI];
  bit            m_locked [NI];
  int            w_idx    [NI];
  int            w_kind   [NI];   // 0 none, 1 priority, 2 lock owner, 3 round-robin
  logic [AW-1:0] w_addr   [NI];

  typedef struct {
    int            inst;
    int            issue;
    int            due;
    int            idx;
    logic [AW-1:0] addr;
  } pend_t;
  pend_t pend [$];

  task automatic chk(input string name, input int inst,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic decide();
    for (int i = 0; i < NI; i++) begin
      w_idx[i]  = -1;
      w_kind[i] = 0;
      w_addr[i] = '0;
      if (reset_n) begin
        if (pri_of(i) == 1 && req[0]) begin
          w_idx[i] = 0; w_kind[i] = 1;
        end else if (m_locked[i] && req[m_owner[i]] && m_cnt[i] < maxb_of(i)) begin
          w_idx[i] = m_owner[i]; w_kind[i] = 2;
        end else begin
          for (int k = 0; k < N; k++) begin
            if (w_idx[i] < 0 && req[(m_ptr[i] + k) % N]) begin
              w_idx[i] = (m_ptr[i] + k) % N; w_kind[i] = 3;
            end
          end
        end
        if (w_idx[i] >= 0) w_addr[i] = req_addr[w_idx[i]*AW +: AW];
      end
    end
  endtask

  task automatic sample();
    logic [N-1:0]  eg, ev;
    logic [DW-1:0] ed;
    logic          eb;
    @(negedge clk);
    decide();
    for (int i = 0; i < NI; i++) begin
      eg = '0; ev = '0; ed = '0; eb = 1'b0;
      if (w_idx[i] >= 0) eg = 4'(1 << w_idx[i]);
      if (reset_n) begin
        foreach (pend[p]) begin
          if (pend[p].inst == i) begin
            if (pend[p].due == cyc) begin
              ev = 4'(1 << pend[p].idx);
              ed = rom_fn(pend[p].addr);
            end
            if (pend[p].issue < cyc && cyc <= pend[p].due) eb = 1'b1;
          end
        end
      end
      chk("gnt", i, 64'(gnt_o[i]), 64'(eg));
      chk("rom_address", i, 64'(addr_o[i]), 64'(w_addr[i]));
      chk("rsp_valid", i, 64'(rspv_o[i]), 64'(ev));
      chk("busy", i, 64'(busy_o[i]), 64'(eb));
      if (ev != 0) chk("rsp_data", i, 64'(rspd_o[i]), 64'(ed));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        m_ptr[i] = 0; m_owner[i] = 0; m_cnt[i] = 0; m_locked[i] = 1'b0;
      end else begin
        if (w_idx[i] >= 0)
          pend.push_back('{inst: i, issue: cyc, due: cyc + lat_of(i) + 1,
                           idx: w_idx[i], addr: w_addr[i]});
        case (w_kind[i])
          1: begin m_locked[i] = 1'b0; m_cnt[i] = 0; end
          2: begin
            m_cnt[i] = m_cnt[i] + 1;
            m_ptr[i] = (w_idx[i] + 1) % N;
            if (!lock[w_idx[i]] || m_cnt[i] >= maxb_of(i)) begin
              m_locked[i] = 1'b0; m_cnt[i] = 0;
            end
          end
          3: begin
            m_ptr[i] = (w_idx[i] + 1) % N;
            if (lock[w_idx[i]] && maxb_of(i) > 1) begin
              m_locked[i] = 1'b1; m_owner[i] = w_idx[i]; m_cnt[i] = 1;
            end else begin
              m_locked[i] = 1'b0; m_cnt[i] = 0;
            end
          end
          default: begin m_locked[i] = 1'b0; m_cnt[i] = 0; end
        endcase
      end
    end
    if (!reset_n) pend.delete();
    else
      for (int p = pend.size() - 1; p >= 0; p--)
        if (pend[p].due <= cyc) pend.delete(p);
    cyc++;
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < NI; i++) begin
      chk("rst_gnt", i, 64'(gnt_o[i]), 64'd0);
      chk("rst_addr", i, 64'(addr_o[i]), 64'd0);
      chk("rst_rspv", i, 64'(rspv_o[i]), 64'd0);
      chk("rst_rspd", i, 64'(rspd_o[i]), 64'd0);
      chk("rst_busy", i, 64'(busy_o[i]), 64'd0);
    end
  endtask

  // Table vectors: gnt shared by inst 0 and 1, address / responses per inst.
  typedef struct {
    logic [N-1:0]  rq;
    logic [N-1:0]  g;
    logic [AW-1:0] a_addr;
    logic [N-1:0]  rv_a;
    logic [N-1:0]  rv_b;
    logic          busy_b;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b1110, 4'b0010, 9'h05A, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1110, 4'b0100, 9'h0B2, 4'b0000, 4'b0000, 1'b1};
    tbl[2]  = '{4'b1110, 4'b1000, 9'h1C3, 4'b0010, 4'b0000, 1'b1};
    tbl[3]  = '{4'b1110, 4'b0010, 9'h05A, 4'b0100, 4'b0000, 1'b1};
    tbl[4]  = '{4'b1110, 4'b0100, 9'h0B2, 4'b1000, 4'b0010, 1'b1};
    tbl[5]  = '{4'b1110, 4'b1000, 9'h1C3, 4'b0010, 4'b0100, 1'b1};
    tbl[6]  = '{4'b0010, 4'b0010, 9'h05A, 4'b0100, 4'b1000, 1'b1};
    tbl[7]  = '{4'b0000, 4'b0000, 9'h000, 4'b1000, 4'b0010, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 9'h000, 4'b0010, 4'b0100, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 9'h000, 4'b0000, 4'b1000, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 9'h000, 4'b0000, 4'b0010, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 9'h000, 4'b0000, 4'b0000, 1'b0};

    for (int i = 0; i < NI; i++) begin
      m_ptr[i] = 0; m_owner[i] = 0; m_cnt[i] = 0; m_locked[i] = 1'b0;
    end

    // Reset with every requester asking: outputs must stay at zero.
    reset_n = 1'b0; req = '1; lock = '1; req_addr = ADDRS;
    #1;
    for (int k = 0; k < 2; k++) begin
      sample();
      check_all_zero();
      advance();
    end
    reset_n = 1'b1; req = '0; lock = '0;

    // Round-robin fairness, single request at 0x05A, ROM_LAT=3 ordering/busy.
    for (int r = 0; r < 12; r++) begin
      req = tbl[r].rq; lock = '0; req_addr = ADDRS;
      sample();
      chk("tbl_gnt_a", 0, 64'(gnt_o[0]), 64'(tbl[r].g));
      chk("tbl_gnt_b", 1, 64'(gnt_o[1]), 64'(tbl[r].g));
      chk("tbl_addr_a", 0, 64'(addr_o[0]), 64'(tbl[r].a_addr));
      chk("tbl_rspv_a", 0, 64'(rspv_o[0]), 64'(tbl[r].rv_a));
      chk("tbl_rspv_b", 1, 64'(rspv_o[1]), 64'(tbl[r].rv_b));
      chk("tbl_busy_b", 1, 64'(busy_o[1]), 64'(tbl[r].busy_b));
      if (tbl[r].rv_a != 0)
        chk("tbl_rspd_a", 0, 64'(rspd_o[0]), 64'(rom_fn(tbl[r-2].a_addr)));
      advance();
    end

    // Priority preemption of a locked burst.
    reset_n = 1'b0; req = '0; lock = '0;
    cycle();
    reset_n = 1'b1;
    req = 4'b0100; lock = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("burst_owner2", 0, 64'(gnt_o[0]), 64'(4'b0100));
      advance();
    end
    req = 4'b0101;
    sample();
    chk("pri0_preempt", 0, 64'(gnt_o[0]), 64'(4'b0001));
    advance();
    req = 4'b1100;
    sample();
    chk("rearb_from_ptr3", 0, 64'(gnt_o[0]), 64'(4'b1000));
    advance();
    req = '0; lock = '0;
    for (int k = 0; k < 5; k++) cycle();

    // Burst cap of 20 grants.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    req = 4'b1010; lock = 4'b0010;
    for (int k = 0; k < 21; k++) begin
      sample();
      chk("burst_cap_a", 0, 64'(gnt_o[0]), (k < 20) ? 64'(4'b0010) : 64'(4'b1000));
      chk("burst_cap_b", 1, 64'(gnt_o[1]), (k < 20) ? 64'(4'b0010) : 64'(4'b1000));
      advance();
    end
    req = '0; lock = '0;
    for (int k = 0; k < 5; k++) cycle();

    // Reset one cycle after a grant discards the read.
    req = 4'b0010; req_addr = ADDRS;
    sample();
    chk("midflight_gnt_c", 2, 64'(gnt_o[2]), 64'(4'b0010));
    advance();
    reset_n = 1'b0; req = '1; lock = '1;
    sample();
    check_all_zero();
    advance();
    reset_n = 1'b1; req = '0; lock = '0;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("midflight_no_rsp_c", 2, 64'(rspv_o[2]), 64'd0);
      chk("midflight_no_busy_c", 2, 64'(busy_o[2]), 64'd0);
      advance();
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req      = 4'($urandom);
      lock     = 4'($urandom) | 4'($urandom);
      req_addr = 36'({$urandom(), $urandom()});
      reset_n  = ($urandom_range(0, 63) != 0);
      cycle();
    end
    reset_n = 1'b1; req = '0; lock = '0;
    for (int k = 0; k < 6; k++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
